// File: rtl/alu_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_pkg
// Brief    : Shared types and helpers for the multi-byte ALU op sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package alu_seq_pkg;

    localparam int c_BYTE_W = 8;

    typedef enum logic [2:0] {
        NOP = 3'b000,
        XOR = 3'b011,
        ROT = 3'b100,
        AND = 3'b101,
        ADD = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        EXEC  = 2'd1,
        CARRY = 2'd2,
        RESP  = 2'd3
    } seq_state_e;

    function automatic logic is_legal_op(input logic [2:0] op);
        logic legal;
        legal = 1'b0;
        case (op)
            XOR, ROT, AND, ADD: legal = 1'b1;
            default:            legal = 1'b0;
        endcase
        return legal;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_seq_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : alu_seq_rr_arb
// Brief    : Round-robin arbiter; grants the lowest requester at/after ptr.
// Revision : 1.0 - initial release
// ============================================================================
module alu_seq_rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx,
    output logic            grant_valid
);

    int w_j;

    always_comb begin
        grant       = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        w_j         = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_j = int'(ptr) + i;
            if (w_j >= NREQ) begin
                w_j = w_j - NREQ;
            end
            if (!grant_valid && req[w_j]) begin
                grant_valid = 1'b1;
                grant[w_j]  = 1'b1;
                grant_idx   = IDW'(w_j);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_sequencer
// Brief    : Shares one 8-bit ALU among NREQ requesters, running DW-bit ops
//            byte by byte with a software carry chain for ADD.
//            Optional perf counters when ALU_SEQ_PERF_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_seq_pkg::*;
#(
    parameter int NREQ   = 2,
    parameter int NBYTES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0][2:0]       req_cmd,
    input  logic [NREQ-1:0][8*NBYTES-1:0] req_a,
    input  logic [NREQ-1:0][8*NBYTES-1:0] req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [$clog2(NREQ)-1:0]    rsp_id,
    output logic [8*NBYTES-1:0]        rsp_data,
    output logic                       rsp_carry,
    output logic                       rsp_zero,
    output logic                       rsp_par,
    output logic                       rsp_err,
    output logic [2:0]                 alu_cmd,
    output logic [7:0]                 alu_a,
    output logic [7:0]                 alu_b,
    output logic                       alu_sc_i,
    input  logic [7:0]                 alu_rslt,
    input  logic                       alu_sc_o
`ifdef ALU_SEQ_PERF_EN
    ,
    output logic [15:0]                perf_ops,
    output logic [15:0]                perf_stall
`endif
);

    localparam int IDW = $clog2(NREQ);
    localparam int DW  = 8 * NBYTES;
    localparam int BW  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [BW-1:0] c_LAST_BYTE = BW'(NBYTES - 1);

    seq_state_e      state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [2:0]      cmd_q, cmd_d;
    logic [DW-1:0]   a_q, a_d;
    logic [DW-1:0]   b_q, b_d;
    logic [DW-1:0]   res_q, res_d;
    logic [BW-1:0]   byte_q, byte_d;
    logic            carry_q, carry_d;
    logic            exec_sc_q, exec_sc_d;
    logic            err_q, err_d;

    logic [NREQ-1:0] w_grant;
    logic [IDW-1:0]  w_gidx;
    logic            w_gvalid;
    logic            w_idle;
    logic            w_resp;
    int              w_off;

    alu_seq_rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req         (req_valid),
        .ptr         (ptr_q),
        .grant       (w_grant),
        .grant_idx   (w_gidx),
        .grant_valid (w_gvalid)
    );

    // rst_n gates the grant so req_ready drops the instant reset asserts.
    assign w_idle    = (state_q == IDLE) && rst_n;
    assign w_resp    = (state_q == RESP);
    assign w_off     = int'(byte_q) * c_BYTE_W;
    assign req_ready = w_idle ? w_grant : '0;

    assign rsp_valid = w_resp;
    assign rsp_id    = w_resp ? id_q : '0;
    assign rsp_data  = w_resp ? res_q : '0;
    assign rsp_carry = w_resp & carry_q;
    assign rsp_zero  = w_resp & (res_q == '0);
    assign rsp_par   = w_resp & (^res_q);
    assign rsp_err   = w_resp & err_q;
    assign alu_sc_i  = 1'b0;

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        id_d      = id_q;
        cmd_d     = cmd_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        byte_d    = byte_q;
        carry_d   = carry_q;
        exec_sc_d = exec_sc_q;
        err_d     = err_q;
        alu_cmd   = '0;
        alu_a     = '0;
        alu_b     = '0;

        case (state_q)
            IDLE: begin
                if (w_idle && w_gvalid) begin
                    cmd_d     = req_cmd[w_gidx];
                    a_d       = req_a[w_gidx];
                    b_d       = req_b[w_gidx];
                    id_d      = w_gidx;
                    ptr_d     = (w_gidx == IDW'(NREQ - 1)) ? '0 : IDW'(w_gidx + 1'b1);
                    res_d     = '0;
                    byte_d    = '0;
                    carry_d   = 1'b0;
                    exec_sc_d = 1'b0;
                    if (is_legal_op(req_cmd[w_gidx])) begin
                        err_d   = 1'b0;
                        state_d = EXEC;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end

            EXEC: begin
                alu_cmd             = cmd_q;
                alu_a               = a_q[w_off +: 8];
                alu_b               = b_q[w_off +: 8];
                res_d[w_off +: 8]   = alu_rslt;
                // An incoming carry costs one extra +1 pass on this byte.
                if ((cmd_q == ADD) && carry_q) begin
                    exec_sc_d = alu_sc_o;
                    state_d   = CARRY;
                end else begin
                    carry_d = (cmd_q == ADD) && alu_sc_o;
                    if (byte_q == c_LAST_BYTE) begin
                        state_d = RESP;
                    end else begin
                        byte_d = byte_q + 1'b1;
                    end
                end
            end

            CARRY: begin
                alu_cmd           = ADD;
                alu_a             = res_q[w_off +: 8];
                alu_b             = 8'h01;
                res_d[w_off +: 8] = alu_rslt;
                carry_d           = exec_sc_q | alu_sc_o;
                if (byte_q == c_LAST_BYTE) begin
                    state_d = RESP;
                end else begin
                    state_d = EXEC;
                    byte_d  = byte_q + 1'b1;
                end
            end

            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end

            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            ptr_q     <= '0;
            id_q      <= '0;
            cmd_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            byte_q    <= '0;
            carry_q   <= 1'b0;
            exec_sc_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            id_q      <= id_d;
            cmd_q     <= cmd_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            byte_q    <= byte_d;
            carry_q   <= carry_d;
            exec_sc_q <= exec_sc_d;
            err_q     <= err_d;
        end
    end

`ifdef ALU_SEQ_PERF_EN
    logic [15:0] perf_ops_q, perf_ops_d;
    logic [15:0] perf_stall_q, perf_stall_d;

    always_comb begin
        perf_ops_d   = perf_ops_q;
        perf_stall_d = perf_stall_q;
        if (w_resp && rsp_ready && (perf_ops_q != 16'hFFFF)) begin
            perf_ops_d = perf_ops_q + 16'd1;
        end
        if (w_resp && !rsp_ready && (perf_stall_q != 16'hFFFF)) begin
            perf_stall_d = perf_stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_ops_q   <= '0;
            perf_stall_q <= '0;
        end else begin
            perf_ops_q   <= perf_ops_d;
            perf_stall_q <= perf_stall_d;
        end
    end

    assign perf_ops   = perf_ops_q;
    assign perf_stall = perf_stall_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_op_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_sequencer
// Brief    : Directed self-checking bench with a behavioural 8-bit ALU model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_sequencer;

    logic             clk;
    logic             rst_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][2:0]  req_cmd;
    logic [1:0][15:0] req_a;
    logic [1:0][15:0] req_b;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [0:0]       rsp_id;
    logic [15:0]      rsp_data;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_par;
    logic             rsp_err;
    logic [2:0]       alu_cmd;
    logic [7:0]       alu_a;
    logic [7:0]       alu_b;
    logic             alu_sc_i;
    logic [7:0]       alu_rslt;
    logic             alu_sc_o;

    int n_cmp = 0;
    int n_bad = 0;

    alu_op_sequencer #(
        .NREQ   (2),
        .NBYTES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_cmd   (req_cmd),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .rsp_par   (rsp_par),
        .rsp_err   (rsp_err),
        .alu_cmd   (alu_cmd),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sc_i  (alu_sc_i),
        .alu_rslt  (alu_rslt),
        .alu_sc_o  (alu_sc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 8-bit ALU; add ignores sc_i.
    logic [15:0] rot_tmp;
    logic [8:0]  add_tmp;
    always_comb begin
        rot_tmp  = {alu_a, alu_a} << alu_b[2:0];
        add_tmp  = {1'b0, alu_a} + {1'b0, alu_b};
        alu_rslt = 8'h00;
        alu_sc_o = 1'b0;
        case (alu_cmd)
            3'b011: alu_rslt = alu_a ^ alu_b;
            3'b101: alu_rslt = alu_a & alu_b;
            3'b100: alu_rslt = rot_tmp[15:8];
            3'b111: begin
                alu_rslt = add_tmp[7:0];
                alu_sc_o = add_tmp[8];
            end
            default: alu_rslt = 8'h00;
        endcase
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_accept(input int id, input string tag);
        logic got;
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            #1;
            if (req_ready[id]) begin
                got = 1'b1;
                break;
            end
        end
        check_val({tag, ".accept"}, 32'(got), 32'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int exp_lat, input string tag);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 30) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check_val({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    endtask

    task automatic check_rsp(input int id, input logic [15:0] d, input logic c,
                             input logic z, input logic p, input logic e, input string tag);
        check_val({tag, ".id"},    32'(rsp_id),    32'(id));
        check_val({tag, ".data"},  32'(rsp_data),  32'(d));
        check_val({tag, ".carry"}, 32'(rsp_carry), 32'(c));
        check_val({tag, ".zero"},  32'(rsp_zero),  32'(z));
        check_val({tag, ".par"},   32'(rsp_par),   32'(p));
        check_val({tag, ".err"},   32'(rsp_err),   32'(e));
    endtask

    task automatic handshake();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
    endtask

    task automatic run_op(input int id, input logic [2:0] cmd, input logic [15:0] a,
                          input logic [15:0] b, input int lat, input logic [15:0] d,
                          input logic c, input logic z, input logic p, input string tag);
        req_cmd[id]   = cmd;
        req_a[id]     = a;
        req_b[id]     = b;
        req_valid[id] = 1'b1;
        wait_accept(id, tag);
        req_valid[id] = 1'b0;
        wait_rsp(lat, tag);
        check_rsp(id, d, c, z, p, 1'b0, tag);
        handshake();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_cmd   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;

        // Reset state, with requests pending
        repeat (2) @(posedge clk);
        req_valid = 2'b11;
        #2;
        check_val("rst.rsp_valid", 32'(rsp_valid), 32'd0);
        check_val("rst.req_ready", 32'(req_ready), 32'd0);
        check_val("rst.alu_cmd",   32'(alu_cmd),   32'd0);
        check_val("rst.rsp_zero",  32'(rsp_zero),  32'd0);
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1-2: carry chain
        run_op(0, 3'b111, 16'h00FF, 16'h0001, 3, 16'h0100, 1'b0, 1'b0, 1'b1, "t1.add");
        run_op(1, 3'b111, 16'hFFFF, 16'h0001, 3, 16'h0000, 1'b1, 1'b1, 1'b0, "t2.add");
        check_val("idle.alu_cmd", 32'(alu_cmd), 32'd0);
        check_val("idle.alu_a",   32'(alu_a),   32'd0);

        // 3: bytewise ops
        run_op(0, 3'b011, 16'hA5A5, 16'hFF00, 2, 16'h5AA5, 1'b0, 1'b0, 1'b0, "t3.xor");
        run_op(1, 3'b100, 16'h8101, 16'h0101, 2, 16'h0302, 1'b0, 1'b0, 1'b1, "t3.rot");
        run_op(0, 3'b111, 16'h1234, 16'h0101, 2, 16'h1335, 1'b0, 1'b0, 1'b1, "t3.addnc");
        run_op(1, 3'b101, 16'hF0F0, 16'h3C3C, 2, 16'h3030, 1'b0, 1'b0, 1'b0, "t3.and");

        // 4: round robin, pointer currently 0
        req_cmd[0] = 3'b011; req_a[0] = 16'h1234; req_b[0] = 16'h00FF;
        req_cmd[1] = 3'b101; req_a[1] = 16'hF0F0; req_b[1] = 16'h3C3C;
        req_valid  = 2'b11;
        @(negedge clk);
        #1;
        check_val("t4.grant0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_cmd[0] = 3'b111; req_a[0] = 16'h7FFF; req_b[0] = 16'h0001;
        wait_rsp(2, "t4.r0");
        check_rsp(0, 16'h12CB, 1'b0, 1'b0, 1'b1, 1'b0, "t4.r0");
        handshake();
        @(negedge clk);
        #1;
        check_val("t4.grant1", 32'(req_ready), 32'd2);
        @(posedge clk);
        #1;
        req_valid[1] = 1'b0;
        wait_rsp(2, "t4.r1");
        check_rsp(1, 16'h3030, 1'b0, 1'b0, 1'b0, 1'b0, "t4.r1");
        handshake();
        @(negedge clk);
        #1;
        check_val("t4.grant0b", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid[0] = 1'b0;
        wait_rsp(3, "t4.r0b");
        check_rsp(0, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, "t4.r0b");
        handshake();

        // 5: illegal cmd, response held under backpressure
        req_cmd[0]   = 3'b000;
        req_a[0]     = 16'h1111;
        req_b[0]     = 16'h2222;
        req_valid[0] = 1'b1;
        wait_accept(0, "t5");
        req_valid[0] = 1'b0;
        req_cmd[1]   = 3'b011;
        req_valid[1] = 1'b1;
        wait_rsp(0, "t5");
        check_rsp(0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b1, "t5");
        for (int k = 0; k < 3; k++) begin
            check_val("t5.hold_valid", 32'(rsp_valid), 32'd1);
            check_val("t5.hold_err",   32'(rsp_err),   32'd1);
            check_val("t5.hold_data",  32'(rsp_data),  32'd0);
            check_val("t5.no_grant",   32'(req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        req_valid[1] = 1'b0;
        handshake();
        check_val("t5.released", 32'(rsp_valid), 32'd0);

        // 6: reset mid-EXEC drops the op and restarts arbitration at 0
        req_cmd[0]   = 3'b111;
        req_a[0]     = 16'h00FF;
        req_b[0]     = 16'h0001;
        req_valid[0] = 1'b1;
        wait_accept(0, "t6");
        req_valid[0] = 1'b0;
        check_val("t6.exec_cmd", 32'(alu_cmd), 32'd7);
        check_val("t6.exec_a",   32'(alu_a),   32'hFF);
        req_cmd[0] = 3'b101; req_a[0] = 16'hFFFF; req_b[0] = 16'h00FF;
        req_valid  = 2'b11;
        #1;
        check_val("t6.busy_ready", 32'(req_ready), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        check_val("t6.rst_valid", 32'(rsp_valid), 32'd0);
        check_val("t6.rst_ready", 32'(req_ready), 32'd0);
        check_val("t6.rst_cmd",   32'(alu_cmd),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_val("t6.grant0", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 2'b00;
        wait_rsp(2, "t6.r0");
        check_rsp(0, 16'h00FF, 1'b0, 1'b0, 1'b0, 1'b0, "t6.r0");
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
